// File: rtl/payment_controller.sv
// Coin-operated payment controller: accumulates credit, charges the price latched
// upstream on a buy, and pays out residual credit as one change coin per cycle.
module payment_controller #(
  parameter int COIN_A_VALUE = 5,
  parameter int COIN_B_VALUE = 10,
  parameter int COIN_C_VALUE = 20,
  parameter int CHANGE_HI    = 10,
  parameter int CHANGE_LO    = 5
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] selected_price,
  input  logic       coin_valid,
  input  logic [1:0] coin_type,
  input  logic       buy,
  input  logic       cancel,
  output logic [4:0] credit,
  output logic       coin_reject,
  output logic       dispense,
  output logic       buy_denied,
  output logic       change_valid,
  output logic [4:0] change_value,
  output logic       busy
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    VEND    = 2'd2,
    CHANGE  = 2'd3
  } state_t;

  state_t     state_r;
  state_t     state_s;
  logic [4:0] credit_s;
  logic [4:0] change_value_s;
  logic       coin_reject_s;
  logic       dispense_s;
  logic       buy_denied_s;
  logic       change_valid_s;
  logic       busy_s;
  logic [5:0] coin_val_s;
  logic [5:0] coin_sum_s;
  logic       coin_ok_s;

  // Largest change coin that does not exceed the remaining credit.
  function automatic logic [4:0] change_coin(input logic [4:0] c);
    if (c >= 5'(CHANGE_HI)) begin
      change_coin = 5'(CHANGE_HI);
    end else if (c >= 5'(CHANGE_LO)) begin
      change_coin = 5'(CHANGE_LO);
    end else begin
      change_coin = c;
    end
  endfunction

  // Coin value decode and 6-bit overflow check so credit never wraps.
  always_comb begin
    coin_val_s = 6'd0;
    case (coin_type)
      2'b00:   coin_val_s = 6'(COIN_A_VALUE);
      2'b01:   coin_val_s = 6'(COIN_B_VALUE);
      2'b10:   coin_val_s = 6'(COIN_C_VALUE);
      default: coin_val_s = 6'd0;
    endcase
    coin_sum_s = {1'b0, credit} + coin_val_s;
    coin_ok_s  = (coin_type != 2'b11) && (coin_sum_s <= 6'd31);
  end

  // Next-state, next-credit and next-output logic.
  always_comb begin
    state_s        = state_r;
    credit_s       = credit;
    coin_reject_s  = 1'b0;
    dispense_s     = 1'b0;
    buy_denied_s   = 1'b0;
    change_valid_s = 1'b0;
    change_value_s = 5'd0;
    case (state_r)
      IDLE, COLLECT: begin
        if (state_r == COLLECT && cancel) begin
          coin_reject_s  = coin_valid;
          change_valid_s = 1'b1;
          change_value_s = change_coin(credit);
          credit_s       = credit - change_coin(credit);
          state_s        = CHANGE;
        end else if (buy) begin
          coin_reject_s = coin_valid;
          if (state_r == COLLECT && selected_price != 5'd0 && credit >= selected_price) begin
            credit_s   = credit - selected_price;
            dispense_s = 1'b1;
            state_s    = VEND;
          end else begin
            buy_denied_s = 1'b1;
          end
        end else if (cancel) begin
          coin_reject_s = coin_valid;
        end else if (coin_valid) begin
          if (coin_ok_s) begin
            credit_s = coin_sum_s[4:0];
            state_s  = COLLECT;
          end else begin
            coin_reject_s = 1'b1;
          end
        end else begin
          state_s = state_r;
        end
      end
      VEND, CHANGE: begin
        // The first coin is issued on the edge that enters CHANGE.
        coin_reject_s = coin_valid;
        if (credit != 5'd0) begin
          change_valid_s = 1'b1;
          change_value_s = change_coin(credit);
          credit_s       = credit - change_coin(credit);
          state_s        = CHANGE;
        end else begin
          state_s = IDLE;
        end
      end
      default: begin
        state_s  = IDLE;
        credit_s = 5'd0;
      end
    endcase
    busy_s = (state_s == VEND) || (state_s == CHANGE);
  end

  // State, credit and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r      <= IDLE;
      credit       <= 5'd0;
      coin_reject  <= 1'b0;
      dispense     <= 1'b0;
      buy_denied   <= 1'b0;
      change_valid <= 1'b0;
      change_value <= 5'd0;
      busy         <= 1'b0;
    end else begin
      state_r      <= state_s;
      credit       <= credit_s;
      coin_reject  <= coin_reject_s;
      dispense     <= dispense_s;
      buy_denied   <= buy_denied_s;
      change_valid <= change_valid_s;
      change_value <= change_value_s;
      busy         <= busy_s;
    end
  end

endmodule

// File: tb/tb_payment_controller.sv
// Directed bench for payment_controller: a transaction-level model checked every
// cycle, plus hand-computed literal expectations at key points.
module tb_payment_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [4:0] selected_price;
  logic       coin_valid;
  logic [1:0] coin_type;
  logic       buy;
  logic       cancel;
  logic [4:0] credit;
  logic       coin_reject;
  logic       dispense;
  logic       buy_denied;
  logic       change_valid;
  logic [4:0] change_value;
  logic       busy;

  payment_controller dut (
    .clk(clk), .reset(reset), .selected_price(selected_price),
    .coin_valid(coin_valid), .coin_type(coin_type), .buy(buy), .cancel(cancel),
    .credit(credit), .coin_reject(coin_reject), .dispense(dispense),
    .buy_denied(buy_denied), .change_valid(change_valid),
    .change_value(change_value), .busy(busy)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Model: credit as an integer plus a queue of pre-computed busy cycles.
  typedef struct {
    int         credit;
    logic       dispense;
    logic       cv;
    logic [4:0] cval;
  } ent_t;

  ent_t q[$];
  int   m_credit = 0;
  bit   m_busy = 1'b0;
  logic [4:0] exp_credit = 5'd0;
  logic       exp_reject = 1'b0, exp_dispense = 1'b0, exp_denied = 1'b0;
  logic       exp_cv = 1'b0, exp_busy = 1'b0;
  logic [4:0] exp_cval = 5'd0;

  task automatic push_change(input int start);
    ent_t e;
    int   c;
    c = start;
    while (c > 0) begin
      e.cval     = (c >= 10) ? 5'd10 : (c >= 5) ? 5'd5 : 5'(c);
      c          = c - int'(e.cval);
      e.credit   = c;
      e.dispense = 1'b0;
      e.cv       = 1'b1;
      q.push_back(e);
    end
  endtask

  always @(posedge clk or posedge reset) begin
    ent_t e;
    int   val;
    if (reset) begin
      q.delete();
      m_credit = 0; m_busy = 1'b0;
      exp_credit = 5'd0; exp_reject = 1'b0; exp_dispense = 1'b0; exp_denied = 1'b0;
      exp_cv = 1'b0; exp_cval = 5'd0; exp_busy = 1'b0;
    end else begin
      exp_reject = 1'b0; exp_dispense = 1'b0; exp_denied = 1'b0;
      exp_cv = 1'b0; exp_cval = 5'd0;
      if (m_busy) begin
        exp_reject = coin_valid;
      end else if (cancel && m_credit > 0) begin
        exp_reject = coin_valid;
        push_change(m_credit);
      end else if (buy) begin
        exp_reject = coin_valid;
        if (selected_price != 5'd0 && m_credit >= int'(selected_price)) begin
          e.credit = m_credit - int'(selected_price);
          e.dispense = 1'b1; e.cv = 1'b0; e.cval = 5'd0;
          q.push_back(e);
          push_change(e.credit);
        end else begin
          exp_denied = 1'b1;
        end
      end else if (cancel) begin
        exp_reject = coin_valid;
      end else if (coin_valid) begin
        val = (coin_type == 2'b00) ? 5 : (coin_type == 2'b01) ? 10 : 20;
        if (coin_type != 2'b11 && m_credit + val <= 31) m_credit = m_credit + val;
        else exp_reject = 1'b1;
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        m_credit = e.credit; exp_dispense = e.dispense; exp_cv = e.cv; exp_cval = e.cval;
        m_busy = 1'b1;
      end else begin
        m_busy = 1'b0;
      end
      exp_credit = 5'(m_credit);
      exp_busy   = m_busy;
    end
  end

  // Per-cycle comparison against the model.
  always @(posedge clk) begin
    #1;
    if (!reset) begin
      vectors++;
      if ({credit, coin_reject, dispense, buy_denied, change_valid, change_value, busy} !==
          {exp_credit, exp_reject, exp_dispense, exp_denied, exp_cv, exp_cval, exp_busy}) begin
        miscompares++;
        $display("FAIL model t=%0t got credit=%0d rej=%b disp=%b den=%b cv=%b cval=%0d busy=%b; want credit=%0d rej=%b disp=%b den=%b cv=%b cval=%0d busy=%b",
                 $time, credit, coin_reject, dispense, buy_denied, change_valid, change_value, busy,
                 exp_credit, exp_reject, exp_dispense, exp_denied, exp_cv, exp_cval, exp_busy);
      end
    end
  end

  task automatic lit(input string name, input int act, input int expv);
    vectors++;
    if (act != expv) begin
      miscompares++;
      $display("FAIL %s got %0d want %0d", name, act, expv);
    end
  endtask

  task automatic cyc(input logic cv, input logic [1:0] ct, input logic b, input logic c,
                     input logic [4:0] price);
    @(negedge clk);
    coin_valid = cv; coin_type = ct; buy = b; cancel = c; selected_price = price;
    @(posedge clk);
    #2;
  endtask

  task automatic idle_cyc();
    cyc(1'b0, 2'b00, 1'b0, 1'b0, 5'd0);
  endtask

  initial begin
    reset = 1'b1; selected_price = 5'd0; coin_valid = 1'b0; coin_type = 2'b00;
    buy = 1'b0; cancel = 1'b0;
    repeat (2) @(negedge clk);
    lit("reset_credit", int'(credit), 0);
    lit("reset_busy", int'(busy), 0);
    lit("reset_pulses", int'({coin_reject, dispense, buy_denied, change_valid}), 0);
    reset = 1'b0;

    // Exact payment, no change
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
    lit("credit_15", int'(credit), 15);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 5'd15);
    lit("exact_dispense", int'(dispense), 1);
    lit("exact_credit", int'(credit), 0);
    lit("exact_busy", int'(busy), 1);
    idle_cyc();
    lit("exact_idle", int'({busy, change_valid}), 0);

    // Credit 30, overflow and invalid coins, buy with change 10 then 5
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    lit("credit_30", int'(credit), 30);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
    lit("overflow_reject", int'(coin_reject), 1);
    lit("overflow_credit", int'(credit), 30);
    cyc(1'b1, 2'b11, 1'b0, 1'b0, 5'd0);
    lit("invalid_reject", int'(coin_reject), 1);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 5'd15);
    lit("buy30_credit", int'(credit), 15);
    idle_cyc();
    lit("change1", int'({change_valid, change_value}), 32 + 10);
    idle_cyc();
    lit("change2", int'({change_valid, change_value}), 32 + 5);
    lit("change2_credit", int'(credit), 0);
    idle_cyc();
    lit("after_change", int'(busy), 0);

    // Denied buys, then cancel refund
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 5'd25);
    lit("short_denied", int'(buy_denied), 1);
    lit("short_credit", int'(credit), 10);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 5'd0);
    lit("price0_denied", int'(buy_denied), 1);
    cyc(1'b1, 2'b00, 1'b0, 1'b1, 5'd0);
    lit("cancel_change", int'(change_value), 10);
    lit("cancel_coin_reject", int'(coin_reject), 1);
    idle_cyc();

    // Buy and cancel in IDLE
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 5'd5);
    lit("idle_denied", int'(buy_denied), 1);
    cyc(1'b0, 2'b00, 1'b0, 1'b1, 5'd0);

    // Cancel beats buy: change 10, 10, 5
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 2'b00, 1'b1, 1'b1, 5'd5);
    lit("cancel_nodisp", int'(dispense), 0);
    lit("cancel_credit", int'(credit), 15);
    repeat (4) idle_cyc();

    // Coin during VEND rejected; reset mid-CHANGE clears everything
    cyc(1'b1, 2'b10, 1'b0, 1'b0, 5'd0);
    cyc(1'b1, 2'b01, 1'b0, 1'b0, 5'd0);
    cyc(1'b0, 2'b00, 1'b1, 1'b0, 5'd5);
    lit("vend_credit", int'(credit), 25);
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
    lit("vend_coin_reject", int'(coin_reject), 1);
    lit("vend_first_change", int'(change_value), 10);
    idle_cyc();
    @(negedge clk);
    reset = 1'b1;
    #1;
    lit("async_credit", int'(credit), 0);
    lit("async_outputs", int'({coin_reject, dispense, buy_denied, change_valid, change_value, busy}), 0);
    @(negedge clk);
    reset = 1'b0;
    cyc(1'b1, 2'b00, 1'b0, 1'b0, 5'd0);
    lit("post_reset_credit", int'(credit), 5);
    idle_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
